// File: rtl/alu_rr_sched.sv
// Round-robin scheduler that shares one registered 4-bit ALU between NREQ requesters.
// Define ALU_RR_SCHED_DIVZ_ERR_EN to add the rsp_err divide-by-zero flag output.
module alu_rr_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_oper,
    input  logic [4*NREQ-1:0] req_in1,
    input  logic [4*NREQ-1:0] req_in2,
    output logic [NREQ-1:0]   req_ready,
    output logic [1:0]        alu_oper,
    output logic [3:0]        alu_in1,
    output logic [3:0]        alu_in2,
    input  logic [4:0]        alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [4:0]        rsp_data,
`ifdef ALU_RR_SCHED_DIVZ_ERR_EN
    output logic              rsp_err,
`endif
    output logic              busy
);

    localparam int LCW = $clog2(ALU_LAT + 1);

    if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || ALU_LAT < 1 || ALU_LAT > 4) begin : g_param_check
        $error("alu_rr_sched: illegal NREQ/IDW/ALU_LAT combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [LCW-1:0]   lat_cnt;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   idx;
    logic             accept;

    logic [1:0]       sel_oper;
    logic [3:0]       sel_in1;
    logic [3:0]       sel_in2;

    // Walk the offsets from farthest to nearest so the requester closest to rr_ptr wins.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = IDW'((int'(rr_ptr) + off) % NREQ);
            if (req_valid[idx]) begin
                grant = idx;
            end
        end
    end

    // Accept is gated by rst so no requester ever sees a grant that reset throws away.
    assign accept    = (state == IDLE) && (|req_valid) && !rst;
    assign req_ready = accept ? (NREQ'(1) << grant) : '0;

    assign sel_oper = req_oper[{grant, 1'b0} +: 2];
    assign sel_in1  = req_in1[{grant, 2'b00} +: 4];
    assign sel_in2  = req_in2[{grant, 2'b00} +: 4];

    // NOTE: sequential state uses non-blocking assignments only; the synchronous reset clears
    // every register because rsp_* and alu_* are externally visible from the first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lat_cnt   <= '0;
            alu_oper  <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
`ifdef ALU_RR_SCHED_DIVZ_ERR_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_oper <= sel_oper;
                        alu_in1  <= sel_in1;
                        alu_in2  <= sel_in2;
                        rsp_id   <= grant;
                        lat_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= EXEC;
`ifdef ALU_RR_SCHED_DIVZ_ERR_EN
                        rsp_err  <= (sel_oper == 2'b11) && (sel_in2 == 4'd0);
`endif
                    end
                end
                EXEC: begin
                    // The ALU output for the held operands is valid once lat_cnt reaches ALU_LAT.
                    if (lat_cnt == LCW'(ALU_LAT)) begin
                        rsp_data  <= alu_out;
                        rsp_valid <= 1'b1;
                        lat_cnt   <= '0;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + LCW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        rr_ptr    <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: directed scenarios followed by randomized traffic,
// checked against a behavioural round-robin/ALU reference model.
`timescale 1ns/1ps
module tb_alu_rr_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int ALU_LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_oper;
    logic [4*NREQ-1:0] req_in1;
    logic [4*NREQ-1:0] req_in2;
    logic [NREQ-1:0]   req_ready;
    logic [1:0]        alu_oper;
    logic [3:0]        alu_in1;
    logic [3:0]        alu_in2;
    logic [4:0]        alu_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [4:0]        rsp_data;
    logic              busy;
`ifdef ALU_RR_SCHED_DIVZ_ERR_EN
    logic              rsp_err;
`endif

    int errors = 0;
    int checks = 0;
    int mdl_ptr = 0;

    always #5 clk = ~clk;

    alu_rr_sched #(.NREQ(NREQ), .IDW(IDW), .ALU_LAT(ALU_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_oper  (req_oper),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_ready (req_ready),
        .alu_oper  (alu_oper),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
`ifdef ALU_RR_SCHED_DIVZ_ERR_EN
        .rsp_err   (rsp_err),
`endif
        .busy      (busy)
    );

    // ALU semantics as plain integer arithmetic, reduced modulo 32.
    function automatic logic [4:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int v;
        case (op)
            2'b00:   v = int'(a) + int'(b);
            2'b01:   v = int'(a) * int'(b);
            2'b10:   v = int'(a) - int'(b);
            default: v = (b == 4'd0) ? 0 : int'(a) / int'(b);
        endcase
        return 5'(v & 31);
    endfunction

    // External registered ALU with ALU_LAT pipeline stages.
    logic [4:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_ref(alu_oper, alu_in1, alu_in2);
        for (int k = 1; k < ALU_LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
    end
    assign alu_out = alu_pipe[ALU_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        req_valid[i]        = v;
        req_oper[2*i +: 2]  = op;
        req_in1[4*i +: 4]   = a;
        req_in2[4*i +: 4]   = b;
    endtask

    // First valid requester at or after mdl_ptr, wrapping modulo NREQ.
    function automatic int mdl_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(mdl_ptr + k) % NREQ]) return (mdl_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Called at a negedge with the DUT idle and at least one request valid.
    task automatic serve(input int stall, input bit keep, output int g);
        int n;
        logic [1:0] op;
        logic [3:0] a, b;
        logic [4:0] exp_d;
        rsp_ready = (stall == 0);
        #1;
        g = mdl_grant();
        check("grant_onehot", 32'(req_ready), 32'(1) << g);
        op    = req_oper[2*g +: 2];
        a     = req_in1[4*g +: 4];
        b     = req_in2[4*g +: 4];
        exp_d = alu_ref(op, a, b);
        @(negedge clk);
        if (!keep) req_valid[g] = 1'b0;
        #1;
        check("busy_exec", 32'(busy), 1);
        check("ready_exec", 32'(req_ready), 0);
        check("alu_operands", {22'd0, alu_oper, alu_in1, alu_in2}, {22'd0, op, a, b});
        n = 1;
        while (!rsp_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("rsp_latency", n, ALU_LAT + 2);
        check("rsp_id", 32'(rsp_id), g);
        check("rsp_data", 32'(rsp_data), 32'(exp_d));
        check("busy_resp", 32'(busy), 1);
`ifdef ALU_RR_SCHED_DIVZ_ERR_EN
        check("rsp_err", 32'(rsp_err), 32'((op == 2'b11) && (b == 4'd0)));
`endif
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            check("hold_resp", {20'd0, rsp_valid, rsp_id, rsp_data, req_ready}, {20'd0, 1'b1, IDW'(g), exp_d, 4'b0000});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_released", {30'd0, rsp_valid, busy}, 0);
        mdl_ptr = (g + 1) % NREQ;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bit seen;

        rst = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_oper  = '0;
        req_in1   = '0;
        req_in2   = '0;
        set_req(0, 1'b1, 2'b00, 4'd1, 4'd1);
        set_req(2, 1'b1, 2'b00, 4'd1, 4'd1);
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 0);
        check("reset_regs", {8'd0, alu_oper, alu_in1, alu_in2, rsp_valid, rsp_id, rsp_data, busy},
              32'd0);
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("idle_after_reset", 32'(busy), 0);

        // Single request: 5 + 7.
        set_req(0, 1'b1, 2'b00, 4'd5, 4'd7);
        serve(0, 1'b0, g);
        check("single_grant", g, 0);

        // All requesters continuously valid, op 01 with 3*i; search starts at 1.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b01, 4'd3, 4'(i));
        for (int k = 0; k < 5; k++) begin
            serve(0, 1'b1, g);
            check("rr_order", g, (1 + k) % NREQ);
        end
        req_valid = '0;

        // Backpressure: 15 + 15 held for five cycles.
        set_req(1, 1'b1, 2'b00, 4'd15, 4'd15);
        serve(5, 1'b0, g);

        // Wrap and skip from rr_ptr=2: req 3 (15*15), then req 1 (2-5).
        set_req(3, 1'b1, 2'b01, 4'd15, 4'd15);
        set_req(1, 1'b1, 2'b10, 4'd2, 4'd5);
        serve(0, 1'b0, g);
        check("wrap_first", g, 3);
        serve(1, 1'b0, g);
        check("wrap_second", g, 1);

        // Divide by zero.
        set_req(2, 1'b1, 2'b11, 4'd9, 4'd0);
        serve(0, 1'b0, g);
        check("divz_grant", g, 2);

        // Reset in the middle of EXEC discards the op and clears rr_ptr.
        set_req(1, 1'b1, 2'b00, 4'd4, 4'd4);
        #1;
        check("pre_reset_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_regs", {8'd0, alu_oper, alu_in1, alu_in2, rsp_valid, rsp_id, rsp_data, busy},
              32'd0);
        mdl_ptr = 0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_aborted_rsp", 32'(seen), 0);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b00, 4'(i), 4'(i));
        serve(0, 1'b0, g);
        check("ptr_after_reset", g, 0);
        req_valid = '0;

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1)
                    set_req(i, 1'b1, 2'($urandom), 4'($urandom), 4'($urandom));
            end
            if ($urandom_range(3, 0) == 0) req_valid[$urandom_range(NREQ - 1, 0)] = 1'b0;
            if (req_valid == '0) begin
                #1;
                check("idle_ready", 32'(req_ready), 0);
                @(negedge clk);
                check("idle_busy", 32'(busy), 0);
            end else begin
                serve($urandom_range(2, 0), 1'b0, g);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
